// File: rtl/systolic_conv_pkg.sv
// Shared types, default sizes and arithmetic helpers for the systolic 2-D convolution engine.
// sat_add is only referenced when SYSTOLIC_CONV_SAT_EN is defined.
package systolic_conv_pkg;

    localparam int unsigned DefDw = 8;
    localparam int unsigned DefK  = 2;
    localparam int unsigned DefN  = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StFlush,
        StDrain
    } state_e;

    // Minimum 1-bit width for an index over n entries.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add clamped to the w-bit two's-complement range (w <= 64).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned w);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi) return hi[63:0];
        if (s < lo) return lo[63:0];
        return s[63:0];
    endfunction

endpackage

// File: rtl/systolic_conv2d_if.sv
// Stream/control bundle of the systolic 2-D convolution engine.
// slave is the engine side, master is the feeder/writer side.
interface systolic_conv2d_if
    import systolic_conv_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned AW = 2 * DW + 4
);
    logic                 start;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;

    modport master (
        output start, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, done
    );

    modport slave (
        input  start, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/sa_pe.sv
// One output-stationary PE: multiply pixel by weight and accumulate into an AW-bit register.
// Build option: SYSTOLIC_CONV_SAT_EN saturates the accumulation, otherwise it wraps.
module sa_pe
    import systolic_conv_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned AW = 2 * DW + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic signed [DW-1:0] pixel,
    input  logic signed [DW-1:0] weight,
    output logic signed [AW-1:0] acc
);
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   addend;
    logic signed [AW-1:0]   acc_d;
    logic signed [AW-1:0]   acc_q;

    assign prod   = pixel * weight;
    assign addend = AW'(prod);

`ifdef SYSTOLIC_CONV_SAT_EN
    assign acc_d = AW'(sat_add(64'(acc_q), 64'(addend), AW));
`else
    assign acc_d = acc_q + addend;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/systolic_conv2d.sv
// Output-stationary systolic 2-D convolution: kernel load, raster pixel stream, raster drain.
// Build option: SYSTOLIC_CONV_SAT_EN selects saturating accumulation (default wraps).
module systolic_conv2d
    import systolic_conv_pkg::*;
#(
    parameter int unsigned DW = DefDw,
    parameter int unsigned AW = 2 * DW + 4,
    parameter int unsigned K  = DefK,
    parameter int unsigned N  = DefN
) (
    input logic              clk,
    input logic              rst,
    systolic_conv2d_if.slave bus
);
    localparam int unsigned M   = N - K + 1;
    localparam int unsigned WIW = idx_w(K * K);
    localparam int unsigned NW  = idx_w(N);
    localparam int unsigned DIW = idx_w(M * M);

    state_e state_q, state_d;
    logic clr, in_ready, in_fire, out_valid, out_fire, last_pix, last_out;
    logic mac_v_q, done_q;
    logic [WIW-1:0] widx_q;
    logic [NW-1:0] row_q, col_q, mac_row_q, mac_col_q;
    logic [DIW-1:0] didx_q;
    logic signed [DW-1:0] mac_pix_q;
    logic signed [DW-1:0] kern_q [K*K];
    logic signed [AW-1:0] acc [M*M];

    assign in_ready  = (state_q == StLoadW) || (state_q == StStream);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_valid = (state_q == StDrain);
    assign out_fire  = out_valid && bus.out_ready;
    assign last_pix  = (row_q == NW'(N - 1)) && (col_q == NW'(N - 1));
    assign last_out  = (didx_q == DIW'(M * M - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? acc[didx_q] : '0;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoadW;
                    clr     = 1'b1;
                end
            end
            StLoadW:  if (in_fire && widx_q == WIW'(K * K - 1)) state_d = StStream;
            StStream: if (in_fire && last_pix) state_d = StFlush;
            StFlush:  state_d = StDrain;
            StDrain:  if (out_fire && last_out) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            widx_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            didx_q    <= '0;
            mac_v_q   <= 1'b0;
            mac_pix_q <= '0;
            mac_row_q <= '0;
            mac_col_q <= '0;
            done_q    <= 1'b0;
            kern_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            done_q  <= out_fire && last_out;
            // One-stage MAC pipeline: the PE adds one cycle after the pixel is accepted.
            mac_v_q <= in_fire && (state_q == StStream);
            if (in_fire && state_q == StStream) begin
                mac_pix_q <= bus.in_data;
                mac_row_q <= row_q;
                mac_col_q <= col_q;
                if (col_q == NW'(N - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + NW'(1);
                end else begin
                    col_q <= col_q + NW'(1);
                end
            end
            if (in_fire && state_q == StLoadW) begin
                kern_q[widx_q] <= bus.in_data;
                widx_q         <= widx_q + WIW'(1);
            end
            if (out_fire) didx_q <= last_out ? '0 : didx_q + DIW'(1);
            if (clr) begin
                widx_q <= '0;
                row_q  <= '0;
                col_q  <= '0;
                didx_q <= '0;
            end
        end
    end

    for (genvar i = 0; i < int'(M); i++) begin : g_row
        for (genvar j = 0; j < int'(M); j++) begin : g_col
            logic signed [DW-1:0] wsel;

            // PE(i,j) uses tap (r-i, c-j) only where that tap lies inside the kernel.
            always_comb begin
                wsel = '0;
                for (int kr = 0; kr < int'(K); kr++) begin
                    for (int kc = 0; kc < int'(K); kc++) begin
                        if (mac_row_q == NW'(i + kr) && mac_col_q == NW'(j + kc)) begin
                            wsel = kern_q[WIW'(kr * int'(K) + kc)];
                        end
                    end
                end
            end

            sa_pe #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (mac_v_q),
                .clr   (clr),
                .pixel (mac_pix_q),
                .weight(wsel),
                .acc   (acc[i * int'(M) + j])
            );
        end
    end
endmodule

// File: tb/tb_systolic_conv2d.sv
// Self-checking bench for systolic_conv2d: table vectors, corner sequences, random jobs vs model.
// Three engine instances (K2/N3/AW20, K2/N3/AW16, K3/N5/AW20) share one stimulus path via sel.
module tb_systolic_conv2d;
    import systolic_conv_pkg::*;

`ifdef SYSTOLIC_CONV_SAT_EN
    localparam int SatExp = 32767;
`else
    localparam int SatExp = -1020;
`endif
    localparam int NV = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int         sel = 0;
    logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       m_in_ready, m_out_valid, m_busy, m_done;
    int         m_out;

    systolic_conv2d_if #(.DW(8), .AW(20)) b0 ();
    systolic_conv2d_if #(.DW(8), .AW(16)) b1 ();
    systolic_conv2d_if #(.DW(8), .AW(20)) b2 ();

    systolic_conv2d #(.DW(8), .AW(20), .K(2), .N(3)) u0 (.clk(clk), .rst(rst), .bus(b0));
    systolic_conv2d #(.DW(8), .AW(16), .K(2), .N(3)) u1 (.clk(clk), .rst(rst), .bus(b1));
    systolic_conv2d #(.DW(8), .AW(20), .K(3), .N(5)) u2 (.clk(clk), .rst(rst), .bus(b2));

    assign b0.start = start && (sel == 0);
    assign b1.start = start && (sel == 1);
    assign b2.start = start && (sel == 2);
    assign b0.in_valid = in_valid && (sel == 0);
    assign b1.in_valid = in_valid && (sel == 1);
    assign b2.in_valid = in_valid && (sel == 2);
    assign b0.in_data = in_data;
    assign b1.in_data = in_data;
    assign b2.in_data = in_data;
    assign b0.out_ready = out_ready;
    assign b1.out_ready = out_ready;
    assign b2.out_ready = out_ready;

    always_comb begin
        m_in_ready  = b0.in_ready;
        m_out_valid = b0.out_valid;
        m_busy      = b0.busy;
        m_done      = b0.done;
        m_out       = int'($signed(b0.out_data));
        case (sel)
            1: begin
                m_in_ready  = b1.in_ready;
                m_out_valid = b1.out_valid;
                m_busy      = b1.busy;
                m_done      = b1.done;
                m_out       = int'($signed(b1.out_data));
            end
            2: begin
                m_in_ready  = b2.in_ready;
                m_out_valid = b2.out_valid;
                m_busy      = b2.busy;
                m_done      = b2.done;
                m_out       = int'($signed(b2.out_data));
            end
            default: ;
        endcase
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int kof(input int s); return (s == 2) ? 3 : 2; endfunction
    function automatic int nof(input int s); return (s == 2) ? 5 : 3; endfunction
    function automatic int awof(input int s); return (s == 1) ? 16 : 20; endfunction

    // Accumulator step at aw bits: clamp or two's-complement wrap.
    function automatic int addw(input longint a, input longint b, input int aw);
        longint s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (aw - 1)) - 1;
        lo = -hi - 1;
`ifdef SYSTOLIC_CONV_SAT_EN
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
`else
        s = s & ((64'sd1 <<< aw) - 1);
        if (s > hi) s = s - (64'sd1 <<< aw);
`endif
        return int'(s);
    endfunction

    // Valid 2-D correlation, each output summed in pixel raster order.
    task automatic model(input int k, input int n, input int aw, input int kern[9],
                         input int img[25], output int exp[9]);
        int m;
        m = n - k + 1;
        exp = '{default: 0};
        for (int i = 0; i < m; i++)
            for (int j = 0; j < m; j++) begin
                int acc;
                acc = 0;
                for (int r = 0; r < n; r++)
                    for (int c = 0; c < n; c++)
                        if (r - i >= 0 && r - i < k && c - j >= 0 && c - j < k)
                            acc = addw(acc, img[r * n + c] * kern[(r - i) * k + (c - j)], aw);
                exp[i * m + j] = acc;
            end
    endtask

    task automatic run_job(input int s, input int kern[9], input int img[25], input int rdy,
                           input int gaps, input int poke, output int got[9]);
        int k, n, m, t0, ngot, guard, held;
        logic hv;
        k = kof(s); n = nof(s); m = n - k + 1;
        got = '{default: 0};
        sel = s;
        @(posedge clk); #1;
        check("idle_in_ready", int'(m_in_ready), 0);
        check("idle_busy", int'(m_busy), 0);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("load_in_ready", int'(m_in_ready), 1);
        check("load_busy", int'(m_busy), 1);
        for (int idx = 0; idx < k * k + n * n; idx++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = 8'(idx < k * k ? kern[idx] : img[idx - k * k]);
            if (poke != 0 && idx == k * k + 2) start = 1'b1;
            if (!m_in_ready) check("in_ready_phase", 0, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
        end
        check("flush_in_ready", int'(m_in_ready), 0);
        check("flush_out_valid", int'(m_out_valid), 0);
        @(posedge clk); #1;
        ngot = 0; guard = 0; hv = 1'b0; held = 0;
        while (ngot < m * m && guard < 200) begin
            if (poke != 0 && guard == 0) start = 1'b1;
            out_ready = (rdy == 0) ? 1'b1 :
                        (rdy == 1) ? (guard % 4 == 0 || guard % 4 == 3) :
                        1'($urandom_range(0, 1));
            check("drain_valid", int'(m_out_valid), 1);
            if (hv) check("drain_hold", m_out, held);
            if (m_out_valid && out_ready) begin
                got[ngot] = m_out;
                ngot++;
                hv = 1'b0;
            end else begin
                hv   = 1'b1;
                held = m_out;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        out_ready = 1'b0;
        if (ngot < m * m) check("drain_timeout", ngot, m * m);
        check("done_pulse", int'(m_done), 1);
        check("busy_with_done", int'(m_busy), 0);
        if (rdy == 0 && gaps == 0) check("min_latency", cyc - t0, 1 + k * k + n * n + 1 + m * m);
        @(posedge clk); #1;
        check("done_single", int'(m_done), 0);
    endtask

    typedef struct packed {
        int sel;
        int rdy;
        int gaps;
        int poke;
    } opt_t;

    opt_t opts [NV];
    int   t_kern [NV][9];
    int   t_img [NV][25];
    int   t_exp [NV][9];

    initial begin
        int got[9];
        int exp[9];
        int rk[9];
        int ri[25];
        int s;
        int ka[9] = '{2, 0, 1, 2, 0, 0, 0, 0, 0};
        int ia[25] = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int ea[9] = '{16, 21, 13, 18, 0, 0, 0, 0, 0};
        int kb[9] = '{-1, 0, 0, 1, 0, 0, 0, 0, 0};
        int ib[25];
        int eb[9] = '{4, 4, 4, 4, 0, 0, 0, 0, 0};
        int es[9] = '{SatExp, SatExp, SatExp, SatExp, 0, 0, 0, 0, 0};
        int k127[9] = '{default: 127};
        int i127[25] = '{default: 127};
        int k1[9] = '{default: 1};
        int i1[25] = '{default: 1};
        int e9[9] = '{default: 9};

        ib = '{default: 0};
        for (int p = 0; p < 9; p++) ib[p] = p + 1;

        opts[0] = '{sel: 0, rdy: 0, gaps: 0, poke: 0}; t_kern[0] = ka;   t_img[0] = ia;   t_exp[0] = ea;
        opts[1] = '{sel: 0, rdy: 1, gaps: 0, poke: 0}; t_kern[1] = ka;   t_img[1] = ia;   t_exp[1] = ea;
        opts[2] = '{sel: 1, rdy: 0, gaps: 0, poke: 0}; t_kern[2] = k127; t_img[2] = i127; t_exp[2] = es;
        opts[3] = '{sel: 0, rdy: 0, gaps: 0, poke: 0}; t_kern[3] = kb;   t_img[3] = ib;   t_exp[3] = eb;
        opts[4] = '{sel: 0, rdy: 2, gaps: 1, poke: 0}; t_kern[4] = kb;   t_img[4] = ib;   t_exp[4] = eb;
        opts[5] = '{sel: 2, rdy: 0, gaps: 0, poke: 1}; t_kern[5] = k1;   t_img[5] = i1;   t_exp[5] = e9;
        opts[6] = '{sel: 0, rdy: 0, gaps: 0, poke: 1}; t_kern[6] = ka;   t_img[6] = ia;   t_exp[6] = ea;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(m_in_ready), 0);
        check("rst_out_valid", int'(m_out_valid), 0);
        check("rst_out_data", m_out, 0);
        check("rst_busy", int'(m_busy), 0);
        check("rst_done", int'(m_done), 0);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            s = opts[v].sel;
            run_job(s, t_kern[v], t_img[v], opts[v].rdy, opts[v].gaps, opts[v].poke, got);
            for (int e = 0; e < (nof(s) - kof(s) + 1) ** 2; e++)
                check($sformatf("vec%0d_out%0d", v, e), got[e], t_exp[v][e]);
        end

        // Reset mid-stream, then a fresh job must carry no residue.
        sel = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int idx = 0; idx < 9; idx++) begin
            in_valid = 1'b1;
            in_data  = 8'(idx < 4 ? ka[idx] : ia[idx - 4]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", int'(m_in_ready), 0);
        check("midrst_out_valid", int'(m_out_valid), 0);
        check("midrst_out_data", m_out, 0);
        check("midrst_busy", int'(m_busy), 0);
        check("midrst_done", int'(m_done), 0);
        in_valid = 1'b1;
        in_data  = 8'd99;
        repeat (2) begin
            @(posedge clk); #1;
            check("idle_ignores_in", int'(m_in_ready), 0);
            check("idle_stays_idle", int'(m_busy), 0);
        end
        in_valid = 1'b0;
        run_job(0, ka, ia, 0, 0, 0, got);
        for (int e = 0; e < 4; e++) check($sformatf("after_rst_out%0d", e), got[e], ea[e]);

        // Random jobs against the reference model.
        for (int r = 0; r < 8; r++) begin
            s = (r < 6) ? 0 : 2;
            for (int p = 0; p < 9; p++) rk[p] = int'($urandom_range(0, 255)) - 128;
            for (int p = 0; p < 25; p++) ri[p] = int'($urandom_range(0, 255)) - 128;
            model(kof(s), nof(s), awof(s), rk, ri, exp);
            run_job(s, rk, ri, 2, 1, 0, got);
            for (int e = 0; e < (nof(s) - kof(s) + 1) ** 2; e++)
                check($sformatf("rand%0d_out%0d", r, e), got[e], exp[e]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/systolic_conv2d.md
# systolic_conv2d

Parametrised output-stationary systolic convolution engine: loads a K×K signed kernel, then streams an N×N signed image in raster order, and accumulates every valid output pixel in an M×M PE array (M = N−K+1). Results are drained in raster order over a valid/ready stream. Generalises the fixed 2×2-kernel / 3×3-image array: adds arbitrary sizes, handshakes, explicit phases, and optional saturation. Sits between the image line feeder and the result writer.

## Interface
- DW, 8: signed input data width (pixels and weights)
- AW, 2*DW+4: signed accumulator/output width
- K, 2: kernel side
- N, 3: image side (N ≥ K)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a job when IDLE, ignored otherwise
- in_data  in  DW  weight (LOAD_W phase) or pixel (STREAM phase), signed
- in_valid  in  1  in_data valid
- in_ready  out  1  high in LOAD_W and STREAM
- out_data  out  AW  result, signed
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last result accepted

## Operation
- FSM states: IDLE → LOAD_W → STREAM → FLUSH → DRAIN → IDLE.
- IDLE: start → LOAD_W; all PE accumulators cleared that cycle.
- LOAD_W: K·K weights accepted (in_valid & in_ready) in raster order, kernel[r][c]; after last → STREAM.
- STREAM: N·N pixels accepted in raster order; row/col counters track (r,c). For each accepted pixel, PE(i,j) adds pixel·kernel[r−i][c−j] if 0 ≤ r−i < K and 0 ≤ c−j < K, else adds 0. After last pixel → FLUSH.
- FLUSH: one cycle, lets the last MAC retire; → DRAIN.
- DRAIN: emits PE(0,0)…PE(M−1,M−1) raster order; index advances on out_valid & out_ready. After final transfer → IDLE, done pulses.
- Arithmetic: product 2·DW bits signed, sign-extended to AW, summed into AW accumulator; overflow per Configuration.
- Gaps in in_valid or out_ready stall the relevant phase indefinitely with no state loss.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, state IDLE, counters and accumulators 0, kernel regs 0.
- in_ready is registered-free combinational from state; asserted first cycle after start accepted.
- MAC latency: accumulator updated 1 cycle after pixel acceptance.
- out_valid asserted first cycle of DRAIN; out_data held stable while out_valid & !out_ready.
- Minimum job: 1 + K² + N² + 1 + M² cycles with no stalls.
- done asserted the cycle after the final out transfer, concurrent with busy=0.
- start during non-IDLE: ignored, no effect.
- rst at any point (mid-load, mid-stream, mid-drain): next cycle all reset values; partial job discarded.
- Simultaneous in_valid in IDLE/FLUSH/DRAIN: ignored (in_ready=0).

## Configuration
- SYSTOLIC_CONV_SAT_EN defined: accumulator additions saturate to [−2^(AW−1), 2^(AW−1)−1].
- Undefined: two's-complement wrap-around at AW bits.

## Structure
- Package systolic_conv_pkg: state enum (IDLE, LOAD_W, STREAM, FLUSH, DRAIN), default DW/K/N constants, sat_add function used under the macro.
- Sub-module sa_pe: one PE — enable, clear, pixel, weight in; AW accumulator out; instantiated M×M via generate.

## Test plan
- Default params, kernel {2,0;1,2}, image {1,2,3;4,5,6;1,2,3} → outputs 16, 21, 13, 18 in order, done after 4th transfer.
- out_ready toggled 1-0-0-1 during drain → each out_data held until accepted, same 16,21,13,18 sequence.
- DW=8, AW=16, kernel all 127, image all 127 → every output 32767 with SYSTOLIC_CONV_SAT_EN, −1020 without.
- Kernel {−1,0;0,1}, image 1..9 raster → outputs 4,4,4,4; random in_valid gaps give identical results.
- rst asserted after 5th pixel, then fresh job with default vectors → outputs 16,21,13,18 (no residue).
- start pulsed in STREAM and DRAIN → ignored; K=3, N=5, all-ones inputs → nine outputs of 9.
